// File: rtl/cache_types_pkg.sv
// Shared types for the icache/dcache to physical-memory arbiter.
// Holds the arbiter FSM state encoding and the last-grant record.
package cache_types_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      RECOVER = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates one physical memory port between an icache (read-only) and a dcache.
// Ties alternate between sides; each transaction ends with a one-cycle RECOVER gap.
module cache_arbiter
   import cache_types_pkg::*;
#(
   parameter int unsigned S_LINE = 256,
   parameter int unsigned S_ADDR = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [S_ADDR-1:0] i_pmem_address,
   input  logic              i_pmem_read,
   output logic [S_LINE-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic [S_ADDR-1:0] d_pmem_address,
   input  logic [S_LINE-1:0] d_pmem_wdata,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   output logic [S_LINE-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic [S_ADDR-1:0] pmem_address,
   output logic [S_LINE-1:0] pmem_wdata,
   output logic              pmem_read,
   output logic              pmem_write,
   input  logic [S_LINE-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t state, state_next;
   grant_t     last_grant, last_grant_next;
   logic       d_req;

   assign d_req = d_pmem_read | d_pmem_write;

   // Returned data is shared; the per-side resp strobe is what qualifies it.
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GRANT_I;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
      end
   end

   // NOTE: every signal driven in a combinational block gets a default first,
   // otherwise an unassigned path infers a latch.
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      case (state)
         IDLE: begin
            if (d_req && (!i_pmem_read || last_grant == GRANT_I)) begin
               state_next      = SERVE_D;
               last_grant_next = GRANT_D;
            end else if (i_pmem_read) begin
               state_next      = SERVE_I;
               last_grant_next = GRANT_I;
            end
         end
         SERVE_I, SERVE_D: begin
            // Only memory completion releases the grant, not a dropped request.
            if (pmem_resp) state_next = RECOVER;
         end
         RECOVER: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pmem_address = d_pmem_address;
      pmem_wdata   = d_pmem_wdata;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      i_pmem_resp  = 1'b0;
      d_pmem_resp  = 1'b0;
      // Strobes are held quiet for the whole time reset is asserted.
      if (!rst) begin
         case (state)
            SERVE_I: begin
               pmem_address = i_pmem_address;
               pmem_read    = i_pmem_read;
               i_pmem_resp  = pmem_resp;
            end
            SERVE_D: begin
               pmem_read   = d_pmem_read;
               pmem_write  = d_pmem_write;
               d_pmem_resp = pmem_resp;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level ownership model.
module tb_cache_arbiter;

   localparam int S_LINE = 256;
   localparam int S_ADDR = 32;
   localparam int OWN_NONE = 0;
   localparam int OWN_I    = 1;
   localparam int OWN_D    = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [S_ADDR-1:0] i_pmem_address;
   logic              i_pmem_read;
   logic [S_LINE-1:0] i_pmem_rdata;
   logic              i_pmem_resp;
   logic [S_ADDR-1:0] d_pmem_address;
   logic [S_LINE-1:0] d_pmem_wdata;
   logic              d_pmem_read;
   logic              d_pmem_write;
   logic [S_LINE-1:0] d_pmem_rdata;
   logic              d_pmem_resp;
   logic [S_ADDR-1:0] pmem_address;
   logic [S_LINE-1:0] pmem_wdata;
   logic              pmem_read;
   logic              pmem_write;
   logic [S_LINE-1:0] pmem_rdata;
   logic              pmem_resp;

   int checks   = 0;
   int failures = 0;
   int i_resp_seen;
   int d_resp_seen;

   // Reference model: who owns memory, whether the post-transaction gap is
   // pending, and which side wins the next simultaneous request.
   int m_owner;
   bit m_gap;
   bit m_d_wins_tie;

   always #5 clk = ~clk;

   cache_arbiter #(.S_LINE(S_LINE), .S_ADDR(S_ADDR)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_pmem_address (i_pmem_address),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
   );

   // The dcache must never ask for a read and a writeback at once.
   always @(posedge clk) begin
      if (!rst) assert (!(d_pmem_read && d_pmem_write))
         else $error("FAIL illegal_d_rw both strobes high");
   end

   task automatic check(input string tag, input logic [S_LINE-1:0] got,
                        input logic [S_LINE-1:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s at %0t: got=%h want=%h", tag, $time, got, want);
      end
   endtask

   function automatic logic [S_LINE-1:0] rand_line();
      logic [S_LINE-1:0] v;
      for (int k = 0; k < S_LINE / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Compare all outputs mid-cycle, then advance the model across the edge.
   task automatic cycle();
      logic [S_ADDR-1:0] e_addr;
      logic [S_LINE-1:0] e_wdata;
      logic e_read, e_write, e_iresp, e_dresp;
      int   winner;
      @(negedge clk);
      e_addr  = d_pmem_address;
      e_wdata = d_pmem_wdata;
      e_read  = 1'b0;
      e_write = 1'b0;
      e_iresp = 1'b0;
      e_dresp = 1'b0;
      if (!rst && m_owner == OWN_I) begin
         e_addr  = i_pmem_address;
         e_read  = i_pmem_read;
         e_iresp = pmem_resp;
      end else if (!rst && m_owner == OWN_D) begin
         e_read  = d_pmem_read;
         e_write = d_pmem_write;
         e_dresp = pmem_resp;
      end
      check("pmem_address", pmem_address, e_addr);
      check("pmem_wdata",   pmem_wdata,   e_wdata);
      check("pmem_read",    pmem_read,    e_read);
      check("pmem_write",   pmem_write,   e_write);
      check("i_pmem_resp",  i_pmem_resp,  e_iresp);
      check("d_pmem_resp",  d_pmem_resp,  e_dresp);
      check("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
      check("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
      i_resp_seen += int'(i_pmem_resp);
      d_resp_seen += int'(d_pmem_resp);
      @(posedge clk);
      if (rst) begin
         m_owner      = OWN_NONE;
         m_gap        = 1'b0;
         m_d_wins_tie = 1'b1;
      end else if (m_owner != OWN_NONE) begin
         if (pmem_resp) begin
            m_owner = OWN_NONE;
            m_gap   = 1'b1;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else begin
         winner = OWN_NONE;
         if ((d_pmem_read || d_pmem_write) && i_pmem_read)
            winner = m_d_wins_tie ? OWN_D : OWN_I;
         else if (d_pmem_read || d_pmem_write)
            winner = OWN_D;
         else if (i_pmem_read)
            winner = OWN_I;
         if (winner != OWN_NONE) begin
            m_owner      = winner;
            m_d_wins_tie = (winner == OWN_I);
         end
      end
      #1;
   endtask

   task automatic quiet_inputs();
      i_pmem_read  = 1'b0;
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
      pmem_resp    = 1'b0;
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      rst            = 1'b1;
      i_pmem_address = 32'h0000_0000;
      d_pmem_address = 32'h0000_0000;
      d_pmem_wdata   = '0;
      pmem_rdata     = '0;
      quiet_inputs();
      m_owner      = OWN_NONE;
      m_gap        = 1'b0;
      m_d_wins_tie = 1'b1;
      run_cycles(2);
      rst = 1'b0;
      run_cycles(1);

      // Icache-only fetch with a five-cycle memory latency.
      i_resp_seen = 0;
      d_resp_seen = 0;
      i_pmem_address = 32'h0000_0040;
      i_pmem_read    = 1'b1;
      cycle();
      check("t_ifetch_latency_read", pmem_read, 1'b1);
      check("t_ifetch_addr", pmem_address, 32'h0000_0040);
      run_cycles(4);
      pmem_rdata = {8{32'hC0DE_0040}};
      pmem_resp  = 1'b1;
      cycle();
      pmem_resp = 1'b0;
      check("t_ifetch_recover_read", pmem_read, 1'b0);
      check("t_ifetch_recover_resp", i_pmem_resp, 1'b0);
      i_pmem_read = 1'b0;
      run_cycles(2);
      check("t_ifetch_iresp_count", i_resp_seen, 1);
      check("t_ifetch_dresp_count", d_resp_seen, 0);

      // Dcache writeback.
      i_resp_seen = 0;
      d_resp_seen = 0;
      d_pmem_address = 32'h0000_1000;
      d_pmem_wdata   = {32{8'hA5}};
      d_pmem_write   = 1'b1;
      cycle();
      check("t_wb_write", pmem_write, 1'b1);
      check("t_wb_wdata", pmem_wdata, {32{8'hA5}});
      run_cycles(3);
      pmem_resp = 1'b1;
      cycle();
      quiet_inputs();
      run_cycles(2);
      check("t_wb_dresp_count", d_resp_seen, 1);
      check("t_wb_iresp_count", i_resp_seen, 0);

      // Tie after reset: dcache, then icache, then dcache again.
      rst = 1'b1;
      run_cycles(1);
      rst = 1'b0;
      i_pmem_address = 32'h0000_2000;
      d_pmem_address = 32'h0000_3000;
      i_pmem_read    = 1'b1;
      d_pmem_read    = 1'b1;
      cycle();
      check("t_tie1_addr", pmem_address, 32'h0000_3000);
      pmem_resp = 1'b1;
      cycle();
      pmem_resp   = 1'b0;
      d_pmem_read = 1'b0;
      run_cycles(2);
      check("t_tie_follow_addr", pmem_address, 32'h0000_2000);
      check("t_tie_follow_read", pmem_read, 1'b1);
      pmem_resp = 1'b1;
      cycle();
      quiet_inputs();
      run_cycles(2);
      i_pmem_read = 1'b1;
      d_pmem_read = 1'b1;
      cycle();
      check("t_tie2_addr", pmem_address, 32'h0000_3000);
      pmem_resp = 1'b1;
      cycle();
      quiet_inputs();
      run_cycles(2);

      // Stray memory response while idle.
      i_resp_seen = 0;
      d_resp_seen = 0;
      pmem_resp = 1'b1;
      run_cycles(2);
      pmem_resp   = 1'b0;
      i_pmem_read = 1'b1;
      cycle();
      check("t_stray_still_idle", pmem_read, 1'b1);
      check("t_stray_resp_count", i_resp_seen + d_resp_seen, 0);
      pmem_resp = 1'b1;
      cycle();
      quiet_inputs();
      run_cycles(2);

      // Reset two cycles into a dcache writeback.
      d_resp_seen = 0;
      d_pmem_write = 1'b1;
      run_cycles(3);
      rst       = 1'b1;
      pmem_resp = 1'b1;
      cycle();
      check("t_rst_write_dropped", pmem_write, 1'b0);
      check("t_rst_no_dresp", d_resp_seen, 0);
      rst = 1'b0;
      quiet_inputs();
      i_pmem_read = 1'b1;
      d_pmem_read = 1'b1;
      cycle();
      check("t_rst_tie_addr", pmem_address, 32'h0000_3000);
      pmem_resp = 1'b1;
      cycle();
      quiet_inputs();
      run_cycles(2);

      // Random traffic, including stray responses and occasional reset.
      for (int n = 0; n < 1500; n++) begin
         int d_op;
         rst            = ($urandom_range(0, 63) == 0);
         i_pmem_read    = ($urandom_range(0, 2) != 0);
         i_pmem_address = $urandom;
         d_op           = int'($urandom_range(0, 3));
         d_pmem_read    = (d_op == 1);
         d_pmem_write   = (d_op == 2);
         d_pmem_address = $urandom;
         d_pmem_wdata   = rand_line();
         pmem_rdata     = rand_line();
         pmem_resp      = ($urandom_range(0, 3) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
